// File: rtl/gfx256_pkg.sv
`default_nettype none
// ============================================================================
// gfx256_pkg
//   Shared types and helpers for the gfx256 cuvz arbiter slice.
//   Revision: 1.0
// ============================================================================
package gfx256_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam int PIX_PW = 16;

  typedef struct packed {
    logic [PIX_PW-1:0] x;
    logic [PIX_PW-1:0] y;
    logic [PIX_PW-1:0] factor0;
    logic [PIX_PW-1:0] factor1;
  } pix_req_t;

  // Successor of idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfx256_cuvz_arb_if.sv
`default_nettype none
// ============================================================================
// gfx256_cuvz_arb_if
//   Requester-side and cuvz-side bus of the shared interpolator arbiter.
//   Revision: 1.0
// ============================================================================
interface gfx256_cuvz_arb_if #(
  parameter int NREQ        = 4,
  parameter int point_width = 16
);
  localparam int SELW = $clog2(NREQ);

  logic [NREQ-1:0]             req_i;
  logic [NREQ-1:0]             lock_i;
  logic [NREQ*point_width-1:0] x_i;
  logic [NREQ*point_width-1:0] y_i;
  logic [NREQ*point_width-1:0] factor0_i;
  logic [NREQ*point_width-1:0] factor1_i;
  logic [NREQ-1:0]             ack_o;
  logic                        cuvz_write_o;
  logic [point_width-1:0]      cuvz_x_o;
  logic [point_width-1:0]      cuvz_y_o;
  logic [point_width-1:0]      cuvz_f0_o;
  logic [point_width-1:0]      cuvz_f1_o;
  logic                        cuvz_ack_i;
  logic [SELW-1:0]             attr_sel_o;
  logic                        busy_o;
  logic                        err_o;
  logic                        clr_err_i;
  logic [31:0]                 pix_cnt_o;

  modport slave (
    input  req_i, lock_i, x_i, y_i, factor0_i, factor1_i, cuvz_ack_i, clr_err_i,
    output ack_o, cuvz_write_o, cuvz_x_o, cuvz_y_o, cuvz_f0_o, cuvz_f1_o,
           attr_sel_o, busy_o, err_o, pix_cnt_o
  );

  modport master (
    output req_i, lock_i, x_i, y_i, factor0_i, factor1_i, cuvz_ack_i, clr_err_i,
    input  ack_o, cuvz_write_o, cuvz_x_o, cuvz_y_o, cuvz_f0_o, cuvz_f1_o,
           attr_sel_o, busy_o, err_o, pix_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/gfx256_rr_pick.sv
`default_nettype none
// ============================================================================
// gfx256_rr_pick
//   Combinational round-robin picker: first set request at or after ptr_i.
//   Revision: 1.0
// ============================================================================
module gfx256_rr_pick #(
  parameter int NREQ = 4
) (
  input  wire logic [NREQ-1:0]         req_i,
  input  wire logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                         valid_o,
  output logic [$clog2(NREQ)-1:0]      idx_o
);
  localparam int SELW = $clog2(NREQ);

  int cand;

  // Walk the ring backwards so the candidate closest to ptr_i is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(ptr_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = SELW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gfx256_cuvz_arb.sv
`default_nettype none
// ============================================================================
// gfx256_cuvz_arb
//   Round-robin sequencer sharing one cuvz interpolator among NREQ requesters.
//   Revision: 1.0
// ============================================================================
module gfx256_cuvz_arb
  import gfx256_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int point_width = 16,
  parameter int TIMEOUT     = 1023
) (
  input wire logic          clk_i,
  input wire logic          rst_i,
  gfx256_cuvz_arb_if.slave  bus
);
  localparam int SELW = $clog2(NREQ);
  localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [point_width-1:0] x;
    logic [point_width-1:0] y;
    logic [point_width-1:0] factor0;
    logic [point_width-1:0] factor1;
  } lat_t;

  arb_state_t        state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  lat_t              lat_q, lat_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic [31:0]       pix_cnt_q, pix_cnt_d;

  logic              pick_valid;
  logic [SELW-1:0]   pick_idx;
  logic              grant;
  logic [SELW-1:0]   grant_idx;
  logic              wd_expired;

  gfx256_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // wd_q counts completed WAIT cycles; the TIMEOUT-th one without ack expires.
  assign wd_expired = (TIMEOUT != 0) && ((int'(wd_q) + 1) == TIMEOUT);

  // A locked owner keeps the interpolator only while it is still requesting.
  always_comb begin
    grant     = 1'b0;
    grant_idx = pick_idx;
    if (!err_q) begin
      if (lock_q && bus.req_i[sel_q]) begin
        grant     = 1'b1;
        grant_idx = sel_q;
      end else if (pick_valid) begin
        grant     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    lat_d     = lat_q;
    lock_d    = lock_q;
    err_d     = err_q;
    ack_d     = '0;
    wd_d      = wd_q;
    pix_cnt_d = pix_cnt_q;

    if (bus.clr_err_i) err_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          sel_d         = grant_idx;
          lat_d.x       = bus.x_i[int'(grant_idx)*point_width +: point_width];
          lat_d.y       = bus.y_i[int'(grant_idx)*point_width +: point_width];
          lat_d.factor0 = bus.factor0_i[int'(grant_idx)*point_width +: point_width];
          lat_d.factor1 = bus.factor1_i[int'(grant_idx)*point_width +: point_width];
          lock_d        = bus.lock_i[grant_idx];
          ptr_d         = SELW'(rr_next(int'(grant_idx), NREQ));
          state_d       = ARB_ISSUE;
        end else begin
          lock_d = 1'b0;
        end
      end
      ARB_ISSUE: begin
        wd_d    = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (bus.cuvz_ack_i) begin
          ack_d[sel_q] = 1'b1;
          pix_cnt_d    = pix_cnt_q + 32'd1;
          state_d      = ARB_DONE;
        end else if (wd_expired) begin
          // Pixel is dropped but still acked so the requester cannot stall.
          ack_d[sel_q] = 1'b1;
          err_d        = 1'b1;
          lock_d       = 1'b0;
          state_d      = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      lat_q     <= '0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= '0;
      wd_q      <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      lat_q     <= lat_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      wd_q      <= wd_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign bus.ack_o        = ack_q;
  assign bus.cuvz_write_o = (state_q == ARB_ISSUE);
  assign bus.cuvz_x_o     = lat_q.x;
  assign bus.cuvz_y_o     = lat_q.y;
  assign bus.cuvz_f0_o    = lat_q.factor0;
  assign bus.cuvz_f1_o    = lat_q.factor1;
  assign bus.attr_sel_o   = sel_q;
  assign bus.busy_o       = (state_q != ARB_IDLE);
  assign bus.err_o        = err_q;
  assign bus.pix_cnt_o    = pix_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx256_cuvz_arb.sv
`default_nettype none
// ============================================================================
// tb_gfx256_cuvz_arb
//   Directed and randomized bench for the cuvz round-robin arbiter.
//   Revision: 1.0
// ============================================================================
module tb_gfx256_cuvz_arb;
  localparam int NR = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gfx256_cuvz_arb_if #(.NREQ(NR), .point_width(PW)) bus ();

  gfx256_cuvz_arb #(.NREQ(NR), .point_width(PW), .TIMEOUT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] px [NR];
  logic [PW-1:0] py [NR];
  logic [PW-1:0] pf0[NR];
  logic [PW-1:0] pf1[NR];
  logic [NR-1:0] req_v;
  logic [NR-1:0] lock_v;
  logic [31:0]   exp_cnt;

  // Reference view of the arbitration rules
  int m_ptr, m_sel;
  bit m_lock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NR; k++) begin
      bus.x_i[k*PW +: PW]       = px[k];
      bus.y_i[k*PW +: PW]       = py[k];
      bus.factor0_i[k*PW +: PW] = pf0[k];
      bus.factor1_i[k*PW +: PW] = pf1[k];
    end
    bus.req_i  = req_v;
    bus.lock_i = lock_v;
  endtask

  task automatic randomize_payload(input int k);
    px[k]  = PW'($urandom);
    py[k]  = PW'($urandom);
    pf0[k] = PW'($urandom);
    pf1[k] = PW'($urandom);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_v          = '0;
    lock_v         = '0;
    bus.cuvz_ack_i = 1'b0;
    bus.clr_err_i  = 1'b0;
    apply();
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
    m_ptr   = 0;
    m_sel   = 0;
    m_lock  = 1'b0;
  endtask

  task automatic wait_write();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.cuvz_write_o) seen = 1'b1;
    end
    chk("write_seen", 64'(seen), 64'd1);
  endtask

  task automatic chk_grant(input string tag, input int idx);
    chk({tag, "_sel"}, 64'(bus.attr_sel_o), 64'(idx));
    chk({tag, "_x"},   64'(bus.cuvz_x_o),   64'(px[idx]));
    chk({tag, "_y"},   64'(bus.cuvz_y_o),   64'(py[idx]));
    chk({tag, "_f0"},  64'(bus.cuvz_f0_o),  64'(pf0[idx]));
    chk({tag, "_f1"},  64'(bus.cuvz_f1_o),  64'(pf1[idx]));
  endtask

  // Called at the ISSUE-cycle sample point; acks in the dly-th WAIT cycle.
  task automatic complete(input int dly, input bit stray, input int idx);
    bit bad = 1'b0;
    bus.cuvz_ack_i = stray;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      bus.cuvz_ack_i = 1'b0;
      if (bus.cuvz_write_o || (bus.ack_o != '0) || bus.err_o || !bus.busy_o) bad = 1'b1;
    end
    chk("wait_quiet", 64'(bad), 64'd0);
    bus.cuvz_ack_i = 1'b1;
    @(negedge clk);
    bus.cuvz_ack_i = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("ack_onehot", 64'(bus.ack_o), 64'(1 << idx));
    chk("pix_cnt", 64'(bus.pix_cnt_o), 64'(exp_cnt));
  endtask

  function automatic int predict();
    if (m_lock && req_v[m_sel]) return m_sel;
    for (int i = 0; i < NR; i++)
      if (req_v[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int exp_rr[5];
    int exp_lk[4];
    bit any_write;
    int idx;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_lk = '{0, 0, 0, 1};
    for (int k = 0; k < NR; k++) begin
      px[k] = '0; py[k] = '0; pf0[k] = '0; pf1[k] = '0;
    end

    // Reset state
    do_reset();
    chk("rst_busy",  64'(bus.busy_o),       64'd0);
    chk("rst_write", 64'(bus.cuvz_write_o), 64'd0);
    chk("rst_ack",   64'(bus.ack_o),        64'd0);
    chk("rst_err",   64'(bus.err_o),        64'd0);
    chk("rst_sel",   64'(bus.attr_sel_o),   64'd0);
    chk("rst_cnt",   64'(bus.pix_cnt_o),    64'd0);
    chk("rst_x",     64'(bus.cuvz_x_o),     64'd0);

    // Single pixel from requester 0
    px[0] = 16'd5; py[0] = 16'd7; pf0[0] = 16'h4000; pf1[0] = 16'h4000;
    req_v = 4'b0001;
    apply();
    @(negedge clk);
    chk("single_write_latency", 64'(bus.cuvz_write_o), 64'd1);
    chk("single_busy", 64'(bus.busy_o), 64'd1);
    chk_grant("single", 0);
    complete(1, 1'b0, 0);
    req_v = '0;
    apply();
    @(negedge clk);
    chk("single_ack_pulse", 64'(bus.ack_o), 64'd0);
    @(negedge clk);
    chk("single_idle", 64'(bus.busy_o), 64'd0);

    // Plain round robin with every requester active
    do_reset();
    for (int k = 0; k < NR; k++) randomize_payload(k);
    req_v = 4'b1111;
    apply();
    for (int p = 0; p < 5; p++) begin
      wait_write();
      chk_grant("rr", exp_rr[p]);
      complete(2, 1'b0, exp_rr[p]);
      randomize_payload(exp_rr[p]);
      apply();
    end

    // Lock burst on requester 0 competing with requester 1
    do_reset();
    for (int k = 0; k < NR; k++) randomize_payload(k);
    req_v  = 4'b0011;
    lock_v = 4'b0001;
    apply();
    for (int p = 0; p < 4; p++) begin
      wait_write();
      chk_grant("lock", exp_lk[p]);
      complete(1, 1'b0, exp_lk[p]);
      randomize_payload(exp_lk[p]);
      if (p == 1) lock_v = '0;
      apply();
    end

    // Ack in the last WAIT cycle before expiry beats the watchdog
    do_reset();
    randomize_payload(1);
    req_v = 4'b0010;
    apply();
    wait_write();
    chk_grant("edge", 1);
    complete(8, 1'b1, 1);
    chk("edge_no_err", 64'(bus.err_o), 64'd0);
    req_v = '0;
    apply();

    // Watchdog expiry, blocked arbitration, clear
    do_reset();
    randomize_payload(2);
    req_v = 4'b0100;
    apply();
    wait_write();
    repeat (8) @(negedge clk);
    chk("to_not_yet", 64'(bus.err_o), 64'd0);
    @(negedge clk);
    chk("to_err", 64'(bus.err_o), 64'd1);
    chk("to_ack", 64'(bus.ack_o), 64'b0100);
    chk("to_cnt", 64'(bus.pix_cnt_o), 64'd0);
    any_write = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.cuvz_write_o || bus.busy_o) any_write = 1'b1;
    end
    chk("to_blocked", 64'(any_write), 64'd0);
    chk("to_sticky", 64'(bus.err_o), 64'd1);
    bus.clr_err_i = 1'b1;
    @(negedge clk);
    bus.clr_err_i = 1'b0;
    chk("to_cleared", 64'(bus.err_o), 64'd0);
    wait_write();
    chk_grant("to_regrant", 2);
    complete(3, 1'b0, 2);

    // Asynchronous reset in WAIT abandons the pixel
    do_reset();
    randomize_payload(0);
    req_v = 4'b0001;
    apply();
    wait_write();
    complete(1, 1'b0, 0);
    wait_write();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy",  64'(bus.busy_o),       64'd0);
    chk("arst_write", 64'(bus.cuvz_write_o), 64'd0);
    chk("arst_cnt",   64'(bus.pix_cnt_o),    64'd0);
    chk("arst_x",     64'(bus.cuvz_x_o),     64'd0);
    bus.cuvz_ack_i = 1'b1;
    req_v = '0;
    apply();
    @(negedge clk);
    chk("arst_no_ack", 64'(bus.ack_o), 64'd0);

    // Pixel counter wrap
    do_reset();
    @(negedge clk);
    force dut.pix_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pix_cnt_q;
    @(negedge clk);
    chk("wrap_preset", 64'(bus.pix_cnt_o), 64'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    randomize_payload(3);
    req_v = 4'b1000;
    apply();
    wait_write();
    complete(2, 1'b0, 3);
    req_v = '0;
    apply();

    // Randomized traffic against the reference rules
    do_reset();
    for (int k = 0; k < NR; k++) randomize_payload(k);
    req_v = 4'($urandom);
    if (req_v == '0) req_v = 4'b0001;
    lock_v = 4'($urandom);
    apply();
    for (int p = 0; p < 60; p++) begin
      idx = predict();
      wait_write();
      chk_grant("rand", idx);
      m_lock = lock_v[idx];
      m_sel  = idx;
      m_ptr  = (idx + 1) % NR;
      complete($urandom_range(1, 7), 1'($urandom_range(0, 1)), idx);
      randomize_payload(idx);
      req_v[idx] = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NR; k++) begin
        if (!req_v[k] && k != idx && $urandom_range(0, 2) == 0) req_v[k] = 1'b1;
        lock_v[k] = ($urandom_range(0, 2) == 0);
      end
      if (req_v == '0) req_v[$urandom_range(0, NR - 1)] = 1'b1;
      apply();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
